serial_tx_frame: RTL and testbench
==================================

Name: serial_tx_frame

Overview:
- Parametrised successor to the fixed 8N1 serial sender.
- Single-clock UART-style transmitter with an internal bit-rate divider, so no separate send clock is needed.
- Configurable data width, stop bits and parity polarity; valid/ready handshake on the parallel side.
- Sits between the byte-producing logic and the serial line pin; drives idle-high NRZ, LSB first.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 2.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- PARITY_ODD, 0, parity polarity when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_W  parallel data; sampled only on handshake.
- tx_valid  input  1  producer has data.
- tx_ready  output  1  block can accept; high only in IDLE.
- dout  output  1  serial line, registered, idle high.
- tx_busy  output  1  high while a frame (start through last stop bit) is on the line.

Behaviour:
- Reset (async, rst_n=0): dout=1, tx_ready=1, tx_busy=0, state IDLE, all counters 0. Mid-frame reset aborts immediately and dout returns high without completing the frame.
- FSM states:
  - IDLE -> START on tx_valid&&tx_ready; tx_data captured into the shift register.
  - START -> DATA.
  - DATA -> PARITY (if compiled in) else STOP, after DATA_W bits.
  - PARITY -> STOP.
  - STOP -> IDLE after STOP_BITS bits.
- Bit timing:
  - The divider counter restarts at the accept edge.
  - Every state bit lasts exactly CLKS_PER_BIT cycles.
  - dout=0 starting the cycle after the accept edge.
- Frame length: CLKS_PER_BIT*(1+DATA_W+P+STOP_BITS) cycles, where P=1 with parity compiled in, else 0.
- Data order: LSB first; the register shifts right with 1 fill.
- Back-to-back frames:
  - tx_ready rises the cycle after the last stop-bit cycle.
  - At least one idle-high cycle separates frames.
- Busy-time isolation: tx_valid while busy is ignored, and tx_data changes during a frame have no effect.
- Output timing: tx_busy=1 from the first start-bit cycle to the last stop-bit cycle inclusive; tx_ready = ~tx_busy, registered.
- Counters: bit counter is ceil(log2(DATA_W+1)) bits; divider is ceil(log2(CLKS_PER_BIT)) bits. Both wrap to 0 on each state advance and never overflow.
- Illegal parameters: elaboration-time assertion failure.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA.
  - Parity bit = ^data XOR PARITY_ODD, computed on the captured data.
  - Frame lengthens by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; PARITY_ODD is ignored.

Decomposition:
- Shared package serial_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Legal parameter range constants.
  - Function frame_bits(DATA_W, STOP_BITS, parity) returning bits per frame.
- One sub-module, serial_baud_tick: divider counter with a sync restart input; outputs a one-cycle bit_end pulse every CLKS_PER_BIT cycles. Reusable by a future receiver.

Test Plan:
- Basic frame, 8N1, CLKS_PER_BIT=4:
  - Stimulus: send 0xA5.
  - Required: dout = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_busy high 40 cycles; tx_ready returns the next cycle.
- Parity, SERIAL_TX_PARITY_EN defined, PARITY_ODD=0:
  - 0xA5 -> parity bit 0.
  - 0x07 -> parity bit 1.
  - With PARITY_ODD=1, both values invert.
- Back-to-back, tx_valid held high with 0x00 then 0xFF:
  - Exactly one idle-high cycle between the frames.
  - Second frame = start 0, eight 1s, stop 1.
  - No data lost or duplicated.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during data bit 3.
  - Required: dout=1 and tx_busy=0 asynchronously. After release, a new 0x3C frame transmits correctly.
- Ignore during busy:
  - Stimulus: toggle tx_data and pulse tx_valid mid-frame.
  - Required: transmitted bits match the captured value; no second frame starts.
- Parameter sweep, DATA_W=7, STOP_BITS=2, CLKS_PER_BIT=2:
  - Stimulus: send 0x55.
  - Required: frame = 0,1,0,1,0,1,0,1,1,1; total 20 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial framing blocks: FSM state encoding,
// legal parameter ranges and a frame-size helper.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_W_MIN       = 5;
  localparam int DATA_W_MAX       = 9;
  localparam int CLKS_PER_BIT_MIN = 2;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

  // Serial bit periods in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned stop_bits,
                                             input bit parity);
    return 32'd1 + data_w + (parity ? 32'd1 : 32'd0) + stop_bits;
  endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// Bit-rate divider: counts CLKS_PER_BIT clocks and pulses o_bit_end on the
// last clock of each bit period; i_restart realigns the period to the next cycle.
module serial_baud_tick
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
    $error("serial_baud_tick: CLKS_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_bit_end = (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/serial_tx_frame.sv
// Parametrised UART-style transmitter, idle-high NRZ, LSB first.
// Define SERIAL_TX_PARITY_EN to insert a parity bit after the data bits.
module serial_tx_frame
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              tx_busy,
  output logic [2:0]        dbg_state
);

  localparam int BIT_CNT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("serial_tx_frame: DATA_W must be 5..9");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("serial_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("serial_tx_frame: PARITY_ODD must be 0 or 1");
  end

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
  // tx_ready is only high in IDLE, so nothing is sampled while a frame is out.
  tx_state_t             r_state;
  logic [DATA_W-1:0]     r_shift;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_dout;
  logic                  r_busy;
  logic                  r_ready;
  logic                  w_accept;
  logic                  w_bit_end;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  logic                  r_parity;
`endif

  assign w_accept = tx_valid && r_ready;

  serial_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_accept),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_dout    <= 1'b1;
      r_busy    <= 1'b0;
      r_ready   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state   <= ST_START;
            r_shift   <= tx_data;
            r_bit_cnt <= '0;
            r_dout    <= 1'b0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity  <= (^tx_data) ^ ODD_BIT;
`endif
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_dout    <= r_shift[0];
            r_shift   <= {1'b1, r_shift[DATA_W-1:1]};
            r_bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LAST_DATA) begin
              r_bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
              r_state   <= ST_PARITY;
              r_dout    <= r_parity;
`else
              r_state   <= ST_STOP;
              r_dout    <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
              r_dout    <= r_shift[0];
              r_shift   <= {1'b1, r_shift[DATA_W-1:1]};
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state   <= ST_STOP;
            r_dout    <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_bit_cnt == LAST_STOP) begin
              // Frame done: ready rises the cycle after the last stop-bit cycle.
              r_state   <= ST_IDLE;
              r_bit_cnt <= '0;
              r_busy    <= 1'b0;
              r_ready   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bit_cnt <= '0;
          r_dout    <= 1'b1;
          r_busy    <= 1'b0;
          r_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign dout      = r_dout;
  assign tx_busy   = r_busy;
  assign tx_ready  = r_ready;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Directed bench for serial_tx_frame: per-cycle {ready,busy,dout} expectations
// are queued when a frame is launched and checked as the line is sampled.
module tb_serial_tx_frame;
  import serial_pkg::*;

  localparam int CPB  = 4;
  localparam int DW   = 8;
  localparam int SB   = 1;
  localparam int CPB7 = 2;
  localparam int DW7  = 7;
  localparam int SB7  = 2;
`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, dout, tx_busy;
  logic [2:0] dbg_state;

  logic [6:0] tx_data7 = 7'h00;
  logic       tx_valid7 = 1'b0;
  logic       tx_ready7, dout7, tx_busy7;
  logic [2:0] dbg_state7;

  serial_tx_frame #(
    .DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_ODD(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .dout(dout), .tx_busy(tx_busy), .dbg_state(dbg_state)
  );

  serial_tx_frame #(
    .DATA_W(DW7), .CLKS_PER_BIT(CPB7), .STOP_BITS(SB7), .PARITY_ODD(1)
  ) u_dut7 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data7), .tx_valid(tx_valid7),
    .tx_ready(tx_ready7), .dout(dout7), .tx_busy(tx_busy7), .dbg_state(dbg_state7)
  );

  // scoreboard: each entry is {ready, busy, dout} for one clock cycle
  logic [2:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input logic b, input int cpb);
    repeat (cpb) exp_q.push_back({1'b0, 1'b1, b});
  endtask

  task automatic push_frame(input logic [8:0] d, input int dw, input int cpb,
                            input int sb, input bit odd);
    logic par;
    par = 1'b0;
    push_bit(1'b0, cpb);
    for (int i = 0; i < dw; i++) begin
      push_bit(d[i], cpb);
      par = par ^ d[i];
    end
    if (PAR) push_bit(par ^ odd, cpb);
    repeat (sb) push_bit(1'b1, cpb);
    exp_q.push_back(3'b101);
  endtask

  // driver: called at a negedge while the target is idle
  task automatic launch(input bit which, input logic [8:0] d);
    if (which) begin
      tx_data7 = d[6:0];
      tx_valid7 = 1'b1;
    end else begin
      tx_data = d[7:0];
      tx_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_valid7 = 1'b0;
  endtask

  task automatic drain(input bit which, input int n, input string tag);
    logic [2:0] e, obs;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      e = exp_q.pop_front();
      obs = which ? {tx_ready7, tx_busy7, dout7} : {tx_ready, tx_busy, dout};
      check(tag, obs, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int flen;
    flen = int'(frame_bits(DW, SB, PAR)) * CPB + 1;

    repeat (3) @(negedge clk);
    check("reset_lines", {tx_ready, tx_busy, dout}, 3'b101);
    check("reset_state", dbg_state, 3'(ST_IDLE));
    check("reset_lines7", {tx_ready7, tx_busy7, dout7}, 3'b101);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frames (parity bit included when compiled in)
    push_frame(9'h0A5, DW, CPB, SB, 1'b0);
    launch(1'b0, 9'h0A5);
    drain(1'b0, exp_q.size(), "frame_a5");
    push_frame(9'h007, DW, CPB, SB, 1'b0);
    launch(1'b0, 9'h007);
    drain(1'b0, exp_q.size(), "frame_07");

    // back-to-back with tx_valid held high
    push_frame(9'h000, DW, CPB, SB, 1'b0);
    push_frame(9'h0FF, DW, CPB, SB, 1'b0);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    drain(1'b0, flen + 1, "b2b_first");
    tx_valid = 1'b0;
    drain(1'b0, exp_q.size(), "b2b_second");

    // tx_data / tx_valid activity during a frame is ignored
    push_frame(9'h096, DW, CPB, SB, 1'b0);
    launch(1'b0, 9'h096);
    drain(1'b0, 10, "busy_ign");
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    drain(1'b0, 8, "busy_ign");
    tx_data = 8'hF0;
    drain(1'b0, 4, "busy_ign");
    tx_valid = 1'b0;
    drain(1'b0, exp_q.size(), "busy_ign");
    repeat (3) exp_q.push_back(3'b101);
    drain(1'b0, exp_q.size(), "no_second_frame");

    // reset during data bit 3
    push_frame(9'h0A5, DW, CPB, SB, 1'b0);
    launch(1'b0, 9'h0A5);
    drain(1'b0, CPB * 4 + 1, "pre_reset");
    rst_n = 1'b0;
    #1;
    check("async_reset_lines", {tx_ready, tx_busy, dout}, 3'b101);
    check("async_reset_state", dbg_state, 3'(ST_IDLE));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_frame(9'h03C, DW, CPB, SB, 1'b0);
    launch(1'b0, 9'h03C);
    drain(1'b0, exp_q.size(), "post_reset_3c");

    // parameter sweep instance: 7 data bits, 2 stop bits, 2 clocks per bit, odd parity
    push_frame(9'h055, DW7, CPB7, SB7, 1'b1);
    launch(1'b1, 9'h055);
    drain(1'b1, exp_q.size(), "sweep_55");
    check("sweep_idle_state", dbg_state7, 3'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
